// File: rtl/ccff_pkg.sv
// Shared definitions for the configuration-chain loader: FSM states and
// default geometry.
package ccff_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_LOAD = 1'b1
   } ccff_state_e;

   localparam int DEF_WORD_W    = 32;
   localparam int DEF_CHAIN_LEN = 1024;

endpackage

// File: rtl/ccff_word_serializer.sv
// Word-wide parallel-to-serial shifter, MSB first, with a count of bits
// still waiting to be shifted out.
module ccff_word_serializer
   import ccff_pkg::*;
#(
   parameter int WORD_W = DEF_WORD_W,
   parameter int BL_W   = $clog2(WORD_W + 1)
) (
   input  logic              prog_clk,
   input  logic              pReset,
   input  logic              clr,
   input  logic              load,
   input  logic              shift,
   input  logic [WORD_W-1:0] word,
   output logic              msb,
   output logic [BL_W-1:0]   bits_left
);

   logic [WORD_W-1:0] sreg;

   // Load wins over shift so the last bit of one word and the first bit of
   // the next leave on consecutive edges.
   always_ff @(posedge prog_clk or negedge pReset) begin
      if (!pReset) begin
         sreg      <= '0;
         bits_left <= '0;
      end else if (clr) begin
         sreg      <= '0;
         bits_left <= '0;
      end else if (load) begin
         sreg      <= word;
         bits_left <= BL_W'(WORD_W);
      end else if (shift && (bits_left != '0)) begin
         sreg      <= sreg << 1;
         bits_left <= bits_left - BL_W'(1);
      end
   end

   assign msb = sreg[WORD_W-1];

endmodule

// File: rtl/ccff_loader.sv
// Streams configuration words into a serial DFFR chain and packs the bits
// falling out of the chain tail into readback words.
module ccff_loader
   import ccff_pkg::*;
#(
   parameter int WORD_W    = DEF_WORD_W,
   parameter int CHAIN_LEN = DEF_CHAIN_LEN,
   parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
   input  logic              prog_clk,
   input  logic              pReset,
   input  logic              start,
   input  logic              abort,
   input  logic [WORD_W-1:0] cfg_data,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   output logic              ccff_head,
   output logic              ccff_shift_en,
   input  logic              ccff_tail,
   output logic [WORD_W-1:0] rb_data,
   output logic              rb_valid,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  bit_count
);

   localparam int BL_W = $clog2(WORD_W + 1);

   ccff_state_e       state, state_nxt;
   logic [BL_W-1:0]   bits_left;
   logic [WORD_W-1:0] pack, pack_nxt;
   logic [BL_W-1:0]   pcnt;
   logic [31:0]       remain;
   logic              in_load, start_go, shift_go, last_bit, grp_full;
   logic              ser_clr, accept;

   assign in_load       = (state == ST_LOAD);
   assign busy          = in_load;
   assign ccff_shift_en = in_load && (bits_left != '0);
   assign remain        = 32'(CHAIN_LEN) - 32'(bit_count);

   // Only ask for another word while the chain still needs bits beyond
   // those already queued in the serializer.
   assign cfg_ready = in_load && (bits_left <= BL_W'(1)) && (remain > 32'(bits_left));
   assign accept    = cfg_valid && cfg_ready;
   assign shift_go  = ccff_shift_en && !abort;
   assign last_bit  = shift_go && (remain == 32'd1);
   assign start_go  = !in_load && start && !abort;
   assign ser_clr   = start_go || (in_load && (abort || last_bit));
   assign grp_full  = (pcnt == BL_W'(WORD_W - 1));
   assign pack_nxt  = (pack << 1) | WORD_W'(ccff_tail);

   ccff_word_serializer #(
      .WORD_W (WORD_W),
      .BL_W   (BL_W)
   ) u_ser (
      .prog_clk  (prog_clk),
      .pReset    (pReset),
      .clr       (ser_clr),
      .load      (accept),
      .shift     (ccff_shift_en),
      .word      (cfg_data),
      .msb       (ccff_head),
      .bits_left (bits_left)
   );

   always_ff @(posedge prog_clk or negedge pReset) begin
      if (!pReset) state <= ST_IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (start_go) state_nxt = ST_LOAD;
         ST_LOAD: if (abort || last_bit) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Groups are cleared after every emit, so a final short group comes out
   // right-justified with zero upper bits.
   always_ff @(posedge prog_clk or negedge pReset) begin
      if (!pReset) begin
         bit_count <= '0;
         pack      <= '0;
         pcnt      <= '0;
         rb_data   <= '0;
         rb_valid  <= 1'b0;
         done      <= 1'b0;
      end else begin
         done     <= last_bit;
         rb_valid <= 1'b0;
         if (start_go) begin
            bit_count <= '0;
            pack      <= '0;
            pcnt      <= '0;
         end else if (shift_go) begin
            bit_count <= bit_count + CNT_W'(1);
            if (grp_full || last_bit) begin
               rb_data  <= pack_nxt;
               rb_valid <= 1'b1;
               pack     <= '0;
               pcnt     <= '0;
            end else begin
               pack <= pack_nxt;
               pcnt <= pcnt + BL_W'(1);
            end
         end
      end
   end

endmodule

// File: doc/ccff_loader.md
CCFF_LOADER -- requirements
Module: ccff_loader

Interface
REQ-001 The block SHALL have parameter WORD_W, default 32, giving the configuration and readback word width in bits.
REQ-002 The block SHALL have parameter CHAIN_LEN, default 1024 (legal range 1..65535), giving the number of DFFR stages in the target configuration chain.
REQ-003 The block SHALL have parameter CNT_W, default $clog2(CHAIN_LEN+1), giving the width of the bit counter.
REQ-004 Port prog_clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-005 Port pReset, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port start, input, 1 bit: begins a load when the block is idle.
REQ-007 Port abort, input, 1 bit: cancels an in-progress load.
REQ-008 Port cfg_data, input, WORD_W bits: configuration word, shifted out MSB first.
REQ-009 Port cfg_valid, input, 1 bit: cfg_data is valid.
REQ-010 Port cfg_ready, output, 1 bit: the block accepts cfg_data this cycle.
REQ-011 Port ccff_head, output, 1 bit: serial data driven into the head of the chain.
REQ-012 Port ccff_shift_en, output, 1 bit: clock-gate enable; the chain shifts on every edge where this is 1.
REQ-013 Port ccff_tail, input, 1 bit: serial data returned from the tail of the chain.
REQ-014 Port rb_data, output, WORD_W bits: packed readback of the prior chain contents.
REQ-015 Port rb_valid, output, 1 bit: one-cycle strobe qualifying rb_data; there is no backpressure.
REQ-016 Ports busy, output, 1 bit, and done, output, 1 bit: busy is high in LOAD; done is a one-cycle pulse on completion.
REQ-017 Port bit_count, output, CNT_W bits: number of bits shifted in the current or most recent load.

Function
REQ-018 The FSM SHALL have two states, IDLE and LOAD.
REQ-019 In IDLE, start=1 SHALL move the FSM to LOAD on the next edge and clear bit_count, bits_left and the readback packer.
REQ-020 start SHALL be ignored while in LOAD.
REQ-021 cfg_ready SHALL equal (LOAD && bits_left<=1 && (CHAIN_LEN-bit_count) > bits_left).
REQ-022 The serializer SHALL load a word when cfg_valid&&cfg_ready, setting bits_left=WORD_W.
REQ-023 When the last bit of a word shifts in the same cycle that a new word is accepted, the next shift SHALL follow with no bubble.
REQ-024 ccff_shift_en SHALL equal (LOAD && bits_left!=0), and ccff_head SHALL equal the serializer MSB; both are decoded only from registers.
REQ-025 Each shift cycle SHALL decrement bits_left, increment bit_count and shift the serializer left.
REQ-026 When no word is available, ccff_shift_en SHALL stay 0 (stall); no bit is lost or duplicated during a stall.
REQ-027 On a shift cycle where bit_count reaches CHAIN_LEN, the unused serializer bits SHALL be discarded.
REQ-028 In that same case, the next edge SHALL move the FSM to IDLE and pulse done for one cycle.
REQ-029 Readback: on every shift cycle, ccff_tail SHALL be sampled and shifted into the packer LSB.
REQ-030 Every WORD_W sampled bits SHALL produce an rb_valid pulse on the next cycle.
REQ-031 If a final partial group exists at completion, it SHALL be emitted right-justified with upper bits zero, with rb_valid in the same cycle as done.
REQ-032 abort in LOAD SHALL force IDLE on the next edge: ccff_shift_en 0, no done, no rb_valid for the partial group; bit_count holds its value.
REQ-033 If abort and start are both high in IDLE, abort SHALL win and the FSM stays in IDLE.
REQ-034 With CHAIN_LEN < WORD_W, the load SHALL complete after a single word.

Reset
REQ-035 pReset low SHALL asynchronously force: IDLE; all counters, the serializer and the packer to 0; and cfg_ready, ccff_head, ccff_shift_en, rb_valid, rb_data, busy, done and bit_count to 0.
REQ-036 Reset asserted mid-load SHALL leave the chain partially written; recovery is a new start.

Structure
REQ-037 A shared package ccff_pkg SHALL hold the state enum and the default WORD_W and CHAIN_LEN values.
REQ-038 The word serializer SHALL be a sub-module, ccff_word_serializer (load, shift, MSB out, bits_left); the FSM, counter and packer remain in ccff_loader.

Verification (WORD_W=32, CHAIN_LEN=40, behavioural 40-stage DFFR chain model clocked by gated prog_clk)
REQ-039 Reset: pReset=0 mid-load -> all outputs 0 immediately; chain model unclocked afterwards.
REQ-040 Gapless load of 0xA5A50F0F then 0xFF000000 -> 40 consecutive shift cycles; head stream is A5A50F0F MSB-first then 8 ones; done one cycle after the 40th shift; bit_count=40; chain holds that stream.
REQ-041 Stall: cfg_valid low for 5 cycles between the two words -> ccff_shift_en low exactly 5 cycles; final chain contents identical to REQ-040.
REQ-042 Readback: chain preloaded with 40'hF0_1234_5678 (tail-first order) -> rb_data=0xF0123456, then 0x00000078 coincident with done.
REQ-043 Abort: abort at bit_count=17 -> IDLE next cycle, no done or rb_valid, bit_count=17; a new start then completes a full 40-bit load.
REQ-044 start held high during LOAD and simultaneous start/abort in IDLE -> no restart, no state change.
